// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read/write masters: FSM states and AXI encodings.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB        = 4096;

  // Beat counts span 1..1024 before clamping to the burst cap.
  localparam int BEAT_W = 11;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min(remaining words, C_MAX_BURST, words left before the next 4 KB boundary).
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int C_MAX_BURST = 16
) (
  input  logic [29:0]       words_left,
  input  logic [9:0]        addr_word,
  output logic [BEAT_W-1:0] beats
);

  logic [BEAT_W-1:0] to_bound;
  logic [BEAT_W-1:0] lim;

  always_comb begin
    to_bound = BEAT_W'(AXI_4KB / 4) - {1'b0, addr_word};
    lim      = (to_bound < BEAT_W'(C_MAX_BURST)) ? to_bound : BEAT_W'(C_MAX_BURST);
    beats    = (words_left < 30'(lim)) ? BEAT_W'(words_left) : lim;
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read-burst engine: fetches a byte range one INCR burst at a time into the DMA data FIFO.
//
// state | meaning
// IDLE  | waiting for i_start
// CALC  | size next burst, wait until the FIFO can hold all of it
// ADDR  | AR presented, waiting for arready
// DATA  | accepting beats, pushing each one into the FIFO
// DONE  | one-cycle completion pulse
module axi_read_master
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST        = 16,
  parameter int C_FIFO_CNT_WIDTH   = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_read_done,
  output logic                          o_read_error,
  input  logic [C_FIFO_CNT_WIDTH-1:0]   i_fifo_free,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  dma_state_t                  state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [29:0]                 words_left;
  logic [BEAT_W-1:0]           beats_q;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [BEAT_W-1:0]           calc_beats;
  logic                        beat;

  dma_burst_calc #(
    .C_MAX_BURST(C_MAX_BURST)
  ) u_burst_calc (
    .words_left(words_left),
    .addr_word (addr[11:2]),
    .beats     (calc_beats)
  );

  // No backpressure inside a burst: space was reserved before the AR went out.
  assign beat           = (state == ST_DATA) && m_axi_rvalid && m_axi_rready;
  assign o_fifo_wr_en   = beat;
  assign o_fifo_wr_data = beat ? m_axi_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      words_left    <= '0;
      beats_q       <= '0;
      beat_cnt      <= '0;
      o_read_done   <= 1'b0;
      o_read_error  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      o_read_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr         <= i_src_addr & ~(C_M_AXI_ADDR_WIDTH'(3));
            words_left   <= 30'(i_total_len >> 2);
            o_read_error <= 1'b0;
            if ((i_total_len >> 2) == '0) begin
              state       <= ST_DONE;
              o_read_done <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          beats_q <= calc_beats;
          if (32'(i_fifo_free) >= 32'(calc_beats)) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(calc_beats - BEAT_W'(1));
            m_axi_arsize  <= AXI_SIZE_4B;
            m_axi_arburst <= AXI_BURST_INCR;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            beat_cnt      <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (m_axi_rresp != AXI_RESP_OKAY) o_read_error <= 1'b1;
            if (m_axi_rlast) begin
              // Bookkeeping advances by the requested burst even if rlast came early.
              if (beat_cnt + BEAT_W'(1) != beats_q) o_read_error <= 1'b1;
              m_axi_rready <= 1'b0;
              addr         <= addr + C_M_AXI_ADDR_WIDTH'({beats_q, 2'b00});
              words_left   <= words_left - 30'(beats_q);
              if (words_left == 30'(beats_q)) begin
                state       <= ST_DONE;
                o_read_done <= 1'b1;
              end else begin
                state <= ST_CALC;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: behavioural AXI read slave plus per-scenario checks.
module tb_axi_read_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_read_done;
  logic        o_read_error;
  logic [14:0] i_fifo_free;
  logic        o_fifo_wr_en;
  logic [31:0] o_fifo_wr_data;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_read_master dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_src_addr(i_src_addr),
    .i_total_len(i_total_len), .o_read_done(o_read_done), .o_read_error(o_read_error),
    .i_fifo_free(i_fifo_free), .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wr_data(o_fifo_wr_data),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  int ar_count, push_count, done_count, data_bad, ar_field_bad;
  int cyc = 0, last_push_cyc = 0, done_cyc = 0;
  logic [31:0] push_addr;
  logic [31:0] ar_addr_log [0:1023];
  logic [7:0]  ar_len_log  [0:1023];

  bit          burst_active = 0, ar_took = 0, r_took = 0;
  logic [31:0] b_addr, cap_addr;
  int          b_len, cap_len, idx, burst_num;
  int          err_burst = -1, err_beat = -1, last_early = -1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC3A5_0F69 ^ {a[15:0], a[31:16]};
  endfunction

  // Slave + monitor: drive R/AR on the falling edge, observe 1 ns later.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        burst_active = 0; ar_took = 0; r_took = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      end else begin
        if (r_took) begin
          if (m_axi_rlast) begin burst_active = 0; burst_num++; end
          else idx++;
        end
        if (ar_took) begin burst_active = 1; b_addr = cap_addr; b_len = cap_len; idx = 0; end
        m_axi_arready = 1'b1;
        if (burst_active) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mem(b_addr + 32'(4 * idx));
          m_axi_rlast  = (idx == b_len) || (idx == last_early);
          m_axi_rresp  = (burst_num == err_burst && idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        end
        #1;
        ar_took = m_axi_arvalid && m_axi_arready;
        if (ar_took) begin
          cap_addr = m_axi_araddr;
          cap_len  = int'(m_axi_arlen);
          if (ar_count < 1024) begin
            ar_addr_log[ar_count] = m_axi_araddr;
            ar_len_log[ar_count]  = m_axi_arlen;
          end
          if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01) ar_field_bad++;
          ar_count++;
        end
        r_took = m_axi_rvalid && m_axi_rready;
        if (o_fifo_wr_en) begin
          if (o_fifo_wr_data !== mem(push_addr)) data_bad++;
          push_addr = push_addr + 32'd4;
          push_count++;
          last_push_cyc = cyc;
        end
        if (o_read_done) begin done_count++; done_cyc = cyc; end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic clear_stats();
    ar_count = 0; push_count = 0; done_count = 0; data_bad = 0; ar_field_bad = 0; burst_num = 0;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] len);
    @(negedge clk);
    i_src_addr = a; i_total_len = len; push_addr = a & 32'hFFFF_FFFC; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_count == 0; i++) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_start = 0; i_src_addr = 0; i_total_len = 0; i_fifo_free = 15'd16384;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({o_read_done, o_read_error, o_fifo_wr_en, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00000",
        {o_read_done, o_read_error, o_fifo_wr_en, m_axi_arvalid, m_axi_rready});
    end
    checks++;
    if ({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== 45'd0) begin
      errors++; $display("FAIL reset_ar: got %h required 0",
        {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
    end
    checks++;
    if (o_fifo_wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_wdata: got %h required 0", o_fifo_wr_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_64k();
    int bad = 0;
    clear_stats();
    i_fifo_free = 15'd16384;
    start(32'h8000_0000, 32'd65536);
    wait_done(25000);
    for (int i = 0; i < 1024; i++)
      if (ar_addr_log[i] !== 32'h8000_0000 + 32'(i * 64) || ar_len_log[i] !== 8'd15) bad++;
    checks++;
    if (done_count !== 1) begin errors++; $display("FAIL full_done: got %0d required 1", done_count); end
    checks++;
    if (ar_count !== 1024) begin errors++; $display("FAIL full_ar_count: got %0d required 1024", ar_count); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_ar_seq: got %0d bad ARs required 0", bad); end
    checks++;
    if (ar_field_bad !== 0) begin errors++; $display("FAIL full_ar_fields: got %0d bad required 0", ar_field_bad); end
    checks++;
    if (push_count !== 16384) begin errors++; $display("FAIL full_pushes: got %0d required 16384", push_count); end
    checks++;
    if (data_bad !== 0) begin errors++; $display("FAIL full_data: got %0d bad words required 0", data_bad); end
    checks++;
    if (o_read_error !== 1'b0) begin errors++; $display("FAIL full_error: got %b required 0", o_read_error); end
  endtask

  task automatic test_4kb_split();
    clear_stats();
    start(32'h0000_0FF0, 32'd64);
    #2;
    checks++;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL split_arvalid_early: got %b required 0", m_axi_arvalid); end
    @(negedge clk);
    #2;
    checks++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, 32'h0000_0FF0, 8'd3}) begin
      errors++; $display("FAIL split_ar1: got %b %h %0d required 1 00000ff0 3",
        m_axi_arvalid, m_axi_araddr, m_axi_arlen);
    end
    wait_done(200);
    checks++;
    if (ar_count !== 2) begin errors++; $display("FAIL split_ar_count: got %0d required 2", ar_count); end
    checks++;
    if (ar_addr_log[1] !== 32'h0000_1000 || ar_len_log[1] !== 8'd11) begin
      errors++; $display("FAIL split_ar2: got %h %0d required 00001000 11", ar_addr_log[1], ar_len_log[1]);
    end
    checks++;
    if (push_count !== 16 || data_bad !== 0) begin
      errors++; $display("FAIL split_pushes: got %0d pushes %0d bad required 16 0", push_count, data_bad);
    end
    checks++;
    if (done_cyc !== last_push_cyc + 1) begin
      errors++; $display("FAIL split_done_timing: got cycle %0d required %0d", done_cyc, last_push_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    i_fifo_free = 15'd8;
    start(32'h0000_2000, 32'd64);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (ar_count !== 0 || m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got %0d ARs arvalid %b required 0 0", ar_count, m_axi_arvalid);
    end
    @(negedge clk);
    i_fifo_free = 15'd16;
    @(negedge clk);
    #2;
    checks++;
    if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL bp_release: got %b required 1", m_axi_arvalid); end
    wait_done(200);
    checks++;
    if (push_count !== 16 || done_count !== 1) begin
      errors++; $display("FAIL bp_complete: got %0d pushes %0d done required 16 1", push_count, done_count);
    end
    i_fifo_free = 15'd16384;
  endtask

  task automatic test_zero_and_ignored();
    clear_stats();
    start(32'h0000_0100, 32'd0);
    #2;
    checks++;
    if (o_read_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", o_read_done); end
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (done_count !== 1 || ar_count !== 0) begin
      errors++; $display("FAIL zero_quiet: got %0d done %0d ARs required 1 0", done_count, ar_count);
    end
    clear_stats();
    start(32'h0000_3000, 32'd64);
    for (int i = 0; i < 50 && push_count == 0; i++) @(negedge clk);
    @(negedge clk);
    i_src_addr = 32'h0000_9000; i_total_len = 32'd4; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(200);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (push_count !== 16 || ar_count !== 1 || done_count !== 1 || data_bad !== 0) begin
      errors++; $display("FAIL ignored_start: got %0d pushes %0d ARs %0d done %0d bad required 16 1 1 0",
        push_count, ar_count, done_count, data_bad);
    end
  endtask

  task automatic test_error();
    clear_stats();
    err_burst = 1; err_beat = 4;
    start(32'h0000_4000, 32'd128);
    wait_done(300);
    err_burst = -1; err_beat = -1;
    checks++;
    if (o_read_error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b required 1", o_read_error); end
    checks++;
    if (push_count !== 32 || data_bad !== 0 || done_count !== 1) begin
      errors++; $display("FAIL err_transfer: got %0d pushes %0d bad %0d done required 32 0 1",
        push_count, data_bad, done_count);
    end
    clear_stats();
    start(32'h0000_4400, 32'd16);
    #2;
    checks++;
    if (o_read_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", o_read_error); end
    wait_done(100);
    checks++;
    if (push_count !== 4 || done_count !== 1 || o_read_error !== 1'b0) begin
      errors++; $display("FAIL err_next: got %0d pushes %0d done err %b required 4 1 0",
        push_count, done_count, o_read_error);
    end
  endtask

  task automatic test_early_last();
    clear_stats();
    last_early = 9;
    start(32'h0000_5000, 32'd64);
    wait_done(200);
    last_early = -1;
    checks++;
    if (o_read_error !== 1'b1 || push_count !== 10 || done_count !== 1) begin
      errors++; $display("FAIL early_last: got err %b %0d pushes %0d done required 1 10 1",
        o_read_error, push_count, done_count);
    end
  endtask

  task automatic test_mid_reset();
    clear_stats();
    start(32'h0000_6000, 32'd64);
    for (int i = 0; i < 100 && push_count < 7; i++) begin @(negedge clk); #2; end
    checks++;
    if (push_count !== 7) begin errors++; $display("FAIL mrst_reach_beat7: got %0d pushes required 7", push_count); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_read_done, o_read_error, o_fifo_wr_en, m_axi_arvalid, m_axi_rready, o_fifo_wr_data,
         m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== 82'd0) begin
      errors++; $display("FAIL mrst_outputs: got %b%b%b%b%b %h %h %h %h %h required all 0",
        o_read_done, o_read_error, o_fifo_wr_en, m_axi_arvalid, m_axi_rready, o_fifo_wr_data,
        m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (done_count !== 0) begin errors++; $display("FAIL mrst_no_done: got %0d required 0", done_count); end
    clear_stats();
    start(32'h0000_7000, 32'd128);
    wait_done(200);
    checks++;
    if (push_count !== 32 || ar_count !== 2 || done_count !== 1 || data_bad !== 0 || o_read_error !== 1'b0) begin
      errors++; $display("FAIL mrst_restart: got %0d pushes %0d ARs %0d done %0d bad err %b required 32 2 1 0 0",
        push_count, ar_count, done_count, data_bad, o_read_error);
    end
  endtask

  initial begin
    test_reset();
    test_full_64k();
    test_4kb_split();
    test_backpressure();
    test_zero_and_ignored();
    test_error();
    test_early_last();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
